pipe_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage MiniMIPS32 pipeline (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB).

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl.sv | 89 ++++++++
 tb/tb_pipe_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline stall/flush scheduler
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } state_t;

    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_ID   = 5'b00111;
    localparam logic [4:0] STALL_EXE  = 5'b01111;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_INT  = 2'b01;
    localparam logic [1:0] EXC_ERET = 2'b10;

    localparam int          DIV_CYCLES_DEF = 32;
    localparam logic [31:0] EXC_ENTRY_DEF  = 32'h0000_0100;

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush scheduler merging load-use stalls, divider sequencing and MEM-stage exception flushes
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          DIV_CYCLES = DIV_CYCLES_DEF,
    parameter logic [31:0] EXC_ENTRY  = EXC_ENTRY_DEF
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        id_stallreq,
    input  logic        exe_div_req,
    input  logic [1:0]  mem_exc_type,
    input  logic [31:0] cp0_epc,
    output logic [4:0]  stall,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        div_start,
    output logic        div_step,
    output logic        div_done,
    output logic        div_abort
);

    localparam int CW = $clog2(DIV_CYCLES);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            flush_req;

    assign flush_req = (mem_exc_type == EXC_INT) || (mem_exc_type == EXC_ERET);

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by reset so the bus reads idle while reset is held, whatever the inputs do.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = STALL_NONE;
        flush       = 1'b0;
        redirect_pc = 32'h0;
        div_start   = 1'b0;
        div_step    = 1'b0;
        div_done    = 1'b0;
        div_abort   = 1'b0;
        if (cpu_rst_n && flush_req) begin
            flush       = 1'b1;
            redirect_pc = (mem_exc_type == EXC_ERET) ? cp0_epc : EXC_ENTRY;
            div_abort   = state_q != IDLE;
            state_d     = IDLE;
            cnt_d       = '0;
        end else if (cpu_rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (exe_div_req) begin
                        div_start = 1'b1;
                        stall     = STALL_EXE;
                        cnt_d     = CW'(DIV_CYCLES - 1);
                        state_d   = DIV_RUN;
                    end else begin
                        stall = id_stallreq ? STALL_ID : STALL_NONE;
                    end
                end
                DIV_RUN: begin
                    div_step = 1'b1;
                    stall    = STALL_EXE;
                    state_d  = (cnt_q == '0) ? DIV_DONE : DIV_RUN;
                    cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                end
                DIV_DONE: begin
                    div_done = 1'b1;
                    stall    = id_stallreq ? STALL_ID : STALL_NONE;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    a_div_req_held: assert property (@(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
        (state_q == DIV_RUN && !flush_req) |-> exe_div_req);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors for pipe_ctrl with a queue-based scoreboard and independent monitor
module tb_pipe_ctrl;

    localparam logic [4:0]  SE = 5'b01111;
    localparam logic [4:0]  SI = 5'b00111;
    localparam logic [40:0] Z  = '0;

    typedef struct {
        string       name;
        logic [40:0] exp;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_stallreq = 1'b0;
    logic        exe_div_req = 1'b0;
    logic [1:0]  mem_exc_type = 2'b00;
    logic [31:0] cp0_epc = 32'h0;
    logic [4:0]  stall;
    logic        flush, div_start, div_step, div_done, div_abort;
    logic [31:0] redirect_pc;

    item_t q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .id_stallreq (id_stallreq),
        .exe_div_req (exe_div_req),
        .mem_exc_type(mem_exc_type),
        .cp0_epc     (cp0_epc),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .div_start   (div_start),
        .div_step    (div_step),
        .div_done    (div_done),
        .div_abort   (div_abort)
    );

    function automatic logic [40:0] e(input logic [4:0] s, input logic f, input logic [31:0] pc,
                                      input logic st, input logic sp, input logic dn, input logic ab);
        return {s, f, pc, st, sp, dn, ab};
    endfunction

    task automatic cyc(input string n, input logic r, input logic id, input logic dv,
                       input logic [1:0] ex, input logic [40:0] x);
        item_t it;
        @(posedge clk);
        #1;
        rst_n        = r;
        id_stallreq  = id;
        exe_div_req  = dv;
        mem_exc_type = ex;
        it.name = n;
        it.exp  = x;
        q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            item_t it;
            logic [40:0] got;
            it  = q.pop_front();
            got = {stall, flush, redirect_pc, div_start, div_step, div_done, div_abort};
            checks++;
            if (got !== it.exp) begin
                errors++;
                $display("FAIL %s got={stall,flush,pc,st,sp,dn,ab}=%h expected=%h", it.name, got, it.exp);
            end
        end
    end

    initial begin
        cp0_epc = 32'h0000_2040;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] b;
            b = 2'(i);
            cyc("reset_hold", 1'b0, b[0], ~b[0], b, Z);
        end
        cyc("idle", 1'b1, 1'b0, 1'b0, 2'b00, Z);
        cyc("loaduse", 1'b1, 1'b1, 1'b0, 2'b00, e(SI, 0, 0, 0, 0, 0, 0));
        cyc("loaduse_end", 1'b1, 1'b0, 1'b0, 2'b00, Z);
        // single DIV: start, 32 steps, done, idle
        cyc("div_start", 1'b1, 1'b0, 1'b1, 2'b00, e(SE, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 32; i++) cyc("div_step", 1'b1, 1'b0, 1'b1, 2'b00, e(SE, 0, 0, 0, 1, 0, 0));
        cyc("div_done", 1'b1, 1'b0, 1'b1, 2'b00, e(5'b0, 0, 0, 0, 0, 1, 0));
        cyc("div_after", 1'b1, 1'b0, 1'b0, 2'b00, Z);
        // exception at t+10
        cyc("exc_div_start", 1'b1, 1'b0, 1'b1, 2'b00, e(SE, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 9; i++) cyc("exc_div_step", 1'b1, 1'b0, 1'b1, 2'b00, e(SE, 0, 0, 0, 1, 0, 0));
        cyc("exc_flush", 1'b1, 1'b0, 1'b0, 2'b01, e(5'b0, 1, 32'h100, 0, 0, 0, 1));
        for (int i = 0; i < 30; i++) cyc("exc_no_done", 1'b1, 1'b0, 1'b0, 2'b00, Z);
        // ERET with a simultaneous load-use request
        cyc("eret", 1'b1, 1'b1, 1'b0, 2'b10, e(5'b0, 1, 32'h2040, 0, 0, 0, 0));
        cyc("reserved_idle", 1'b1, 1'b1, 1'b0, 2'b11, e(SI, 0, 0, 0, 0, 0, 0));
        cyc("eret_after", 1'b1, 1'b0, 1'b0, 2'b00, Z);
        // back-to-back DIVs, reserved type and ignored load-use during DIV_RUN
        cyc("b2b_start1", 1'b1, 1'b0, 1'b1, 2'b00, e(SE, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 32; i++) cyc("b2b_step1", 1'b1, i[0], 1'b1, 2'b11, e(SE, 0, 0, 0, 1, 0, 0));
        cyc("b2b_done1", 1'b1, 1'b0, 1'b1, 2'b11, e(5'b0, 0, 0, 0, 0, 1, 0));
        cyc("b2b_start2", 1'b1, 1'b0, 1'b1, 2'b00, e(SE, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 32; i++) cyc("b2b_step2", 1'b1, 1'b1, 1'b1, 2'b11, e(SE, 0, 0, 0, 1, 0, 0));
        cyc("b2b_done2_loaduse", 1'b1, 1'b1, 1'b1, 2'b00, e(SI, 0, 0, 0, 0, 1, 0));
        cyc("b2b_after", 1'b1, 1'b0, 1'b0, 2'b00, Z);
        // exception landing on the DIV_DONE cycle
        cyc("dd_start", 1'b1, 1'b0, 1'b1, 2'b00, e(SE, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 32; i++) cyc("dd_step", 1'b1, 1'b0, 1'b1, 2'b00, e(SE, 0, 0, 0, 1, 0, 0));
        cyc("dd_flush", 1'b1, 1'b0, 1'b0, 2'b01, e(5'b0, 1, 32'h100, 0, 0, 0, 1));
        cyc("dd_after", 1'b1, 1'b0, 1'b0, 2'b00, Z);
        // reset mid-division: outputs drop at once, no abort, back in IDLE
        cyc("rst_div_start", 1'b1, 1'b0, 1'b1, 2'b00, e(SE, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 5; i++) cyc("rst_div_step", 1'b1, 1'b0, 1'b1, 2'b00, e(SE, 0, 0, 0, 1, 0, 0));
        cyc("rst_mid_div", 1'b0, 1'b1, 1'b1, 2'b01, Z);
        cyc("rst_mid_div2", 1'b0, 1'b0, 1'b1, 2'b10, Z);
        cyc("rst_release", 1'b1, 1'b0, 1'b0, 2'b00, Z);
        cyc("rst_idle", 1'b1, 1'b0, 1'b0, 2'b00, Z);
        cyc("rst_loaduse", 1'b1, 1'b1, 1'b0, 2'b00, e(SI, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
